weight_packer: RTL
==================

// Module: weight_packer
// PURPOSE
//  Transmit side of the weight-buffer write interface. Accepts one frame of 5 parallel
//  BUFFER_WIDTH-bit weights and serializes it MSB-first into OUTPUT_WIDTH-bit words
//  using the WR_EN/WR_VALID/WR_READY handshake that weight_buffer consumes.
//  Sits between the weight DMA/loader and weight_buffer in the mlp_conv datapath.
// PARAMETERS
//  OUTPUT_WIDTH  32  width of WR_DATA word
//  BUFFER_WIDTH  40  width of each weight lane; depth fixed at 5 lanes
//  (local) FRAME_BITS = 5*BUFFER_WIDTH; NUM_WORDS = ceil(FRAME_BITS/OUTPUT_WIDTH), 7 at defaults
// PORTS
//  CLK          in   1             clock, all state on rising edge
//  RESETN       in   1             asynchronous, active-low reset
//  LD_VALID     in   1             frame valid on LD_DATA_0..4
//  LD_READY     out  1             packer can accept a frame
//  LD_DATA_0..4 in   BUFFER_WIDTH  weight lanes; lane 0 is most significant
//  FLUSH        in   1             synchronous abort of the current frame
//  WR_EN        out  1             frame-active qualifier to weight_buffer
//  WR_VALID     out  1             WR_DATA holds a valid word
//  WR_DATA      out  OUTPUT_WIDTH  serialized word
//  WR_READY     in   1             sink accepts word this cycle
//  FRAME_DONE   out  1             1-cycle pulse after the last word handshakes
// BEHAVIOUR
//  - Reset: state IDLE; LD_READY=1, WR_EN=0, WR_VALID=0, WR_DATA=0, FRAME_DONE=0,
//    shift reg and word_cnt = 0. Async assert takes effect immediately mid-frame; the frame is lost.
//  - FSM IDLE/SEND. IDLE: LD_READY=1. LD_VALID&LD_READY latches
//    shreg={LD_DATA_0,...,LD_DATA_4}, word_cnt=0, next state SEND.
//  - SEND: WR_EN=1, WR_VALID=1, WR_DATA=shreg[FRAME_BITS-1 -: OUTPUT_WIDTH], all registered.
//    First word is valid the cycle after load acceptance (latency 1).
//  - Word handshake = WR_VALID&WR_READY. Shift shreg left by OUTPUT_WIDTH, zero-fill, word_cnt++.
//    WR_VALID=1 with WR_READY=0 holds WR_DATA and WR_VALID stable (no retraction).
//  - Last word: FRAME_BITS%OUTPUT_WIDTH valid bits, left-aligned, low bits zero
//    (8 bits at defaults, in WR_DATA[31:24]).
//  - Handshake on word NUM_WORDS-1: next cycle FRAME_DONE=1, state IDLE (or SEND, see CONFIGURATION),
//    WR_VALID=0, WR_EN=0.
//  - LD_VALID in SEND is ignored unless the preload feature applies; no lane data is sampled.
//  - FLUSH in SEND: next cycle IDLE, WR_VALID=0, WR_EN=0, word_cnt=0, no FRAME_DONE. FLUSH wins over
//    a simultaneous word handshake. FLUSH in IDLE: no effect, and a same-cycle load is accepted.
//  - word_cnt is $clog2(NUM_WORDS+1) bits and never exceeds NUM_WORDS-1.
// CONFIGURATION
//  WEIGHT_PACKER_PRELOAD_EN defined:
//  - LD_READY is also 1 during SEND when word_cnt==NUM_WORDS-1 and WR_READY=1.
//  - A load in that cycle reloads shreg, so SEND continues with zero bubble. WR_VALID stays 1 and
//    FRAME_DONE still pulses for the finished frame.
//  - A FLUSH in that same cycle cancels both frames.
//  Not defined: LD_READY=0 throughout SEND. A minimum of 1 IDLE cycle (WR_VALID=0) separates frames.
// TESTING
//  Frame values: LD_DATA_0..4 = 40'h0102030405, 40'h060708090A, 40'h0B0C0D0E0F, 40'h1011121314,
//  40'h1516171819. Scoreboard compares every word handshake.
//  1 Reset then load frame, WR_READY=1 held -> 7 words 01020304, 05060708, 090A0B0C, 0D0E0F10,
//    11121314, 15161718, 19000000. FRAME_DONE pulses once, the cycle after word 7.
//  2 Same frame, WR_READY random 50% -> identical word sequence; WR_DATA stable while stalled.
//  3 FLUSH after word 3 handshakes -> WR_VALID=0 next cycle, no FRAME_DONE. Reload -> word 1 = 01020304.
//  4 RESETN low mid-frame (after word 4) -> all outputs at reset values asynchronously.
//    LD_READY=1 after release.
//  5 Two frames back-to-back, LD_VALID held -> without macro, 1-cycle WR_VALID gap.
//    With WEIGHT_PACKER_PRELOAD_EN, 14 contiguous words and 2 FRAME_DONE pulses.
//  6 LD_VALID pulsed during SEND (not in the last-word slot) -> ignored; current frame is unchanged.

Source files
------------

// File: rtl/weight_packer.sv
// weight_packer: transmit side of the weight-buffer write interface.
// Latches one frame of five BUFFER_WIDTH-bit weight lanes (lane 0 most
// significant) and serializes it MSB-first into OUTPUT_WIDTH-bit words over
// the WR_EN/WR_VALID/WR_READY handshake consumed by weight_buffer.
//
// Ports:
//   CLK, RESETN          clock (rising edge), asynchronous active-low reset
//   LD_VALID/LD_READY    frame load handshake; LD_DATA_0..4 are the lanes
//   FLUSH                synchronous abort of the frame being sent
//   WR_EN, WR_VALID      frame-active qualifier and word-valid (registered)
//   WR_DATA              serialized word (registered), last word left-aligned
//   WR_READY             sink accepts the current word
//   FRAME_DONE           one-cycle pulse after the last word handshakes
//
// Optional feature: define WEIGHT_PACKER_PRELOAD_EN to allow a new frame to be
// loaded in the last-word handshake cycle so back-to-back frames have no bubble.
module weight_packer #(
   parameter int unsigned OUTPUT_WIDTH = 32,
   parameter int unsigned BUFFER_WIDTH = 40
) (
   input  logic                    CLK,
   input  logic                    RESETN,
   input  logic                    LD_VALID,
   output logic                    LD_READY,
   input  logic [BUFFER_WIDTH-1:0] LD_DATA_0,
   input  logic [BUFFER_WIDTH-1:0] LD_DATA_1,
   input  logic [BUFFER_WIDTH-1:0] LD_DATA_2,
   input  logic [BUFFER_WIDTH-1:0] LD_DATA_3,
   input  logic [BUFFER_WIDTH-1:0] LD_DATA_4,
   input  logic                    FLUSH,
   output logic                    WR_EN,
   output logic                    WR_VALID,
   output logic [OUTPUT_WIDTH-1:0] WR_DATA,
   input  logic                    WR_READY,
   output logic                    FRAME_DONE
);

   localparam int unsigned FRAME_BITS = 5 * BUFFER_WIDTH;
   localparam int unsigned NUM_WORDS  = (FRAME_BITS + OUTPUT_WIDTH - 1) / OUTPUT_WIDTH;
   localparam int unsigned CNT_W      = $clog2(NUM_WORDS + 1);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_WORDS - 1);

   typedef enum logic {
      IDLE = 1'b0,
      SEND = 1'b1
   } state_t;

   state_t                  state_q,  state_d;
   logic [FRAME_BITS-1:0]   shreg_q,  shreg_d;
   logic [CNT_W-1:0]        cnt_q,    cnt_d;
   logic                    active_q, active_d;
   logic [OUTPUT_WIDTH-1:0] data_q,   data_d;
   logic                    done_q,   done_d;

   logic [FRAME_BITS-1:0]   frame;
   logic [FRAME_BITS-1:0]   shifted;
   logic                    last_word;
   logic                    handshake;
   logic                    ld_ready;
   logic                    load;

   // State and output registers
   always_ff @(posedge CLK or negedge RESETN) begin
      if (!RESETN) begin
         state_q  <= IDLE;
         shreg_q  <= '0;
         cnt_q    <= '0;
         active_q <= 1'b0;
         data_q   <= '0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         shreg_q  <= shreg_d;
         cnt_q    <= cnt_d;
         active_q <= active_d;
         data_q   <= data_d;
         done_q   <= done_d;
      end
   end

   // Next-state, shift and output logic
   always_comb begin
      state_d  = state_q;
      shreg_d  = shreg_q;
      cnt_d    = cnt_q;
      active_d = active_q;
      data_d   = data_q;
      done_d   = 1'b0;

      frame     = {LD_DATA_0, LD_DATA_1, LD_DATA_2, LD_DATA_3, LD_DATA_4};
      shifted   = shreg_q << OUTPUT_WIDTH;
      last_word = (cnt_q == LAST_CNT);
      handshake = active_q & WR_READY;
`ifdef WEIGHT_PACKER_PRELOAD_EN
      // Reopen the load port in the slot where the last word is being taken
      ld_ready  = (state_q == IDLE) | ((state_q == SEND) & last_word & WR_READY);
`else
      ld_ready  = (state_q == IDLE);
`endif
      load      = LD_VALID & ld_ready;

      case (state_q)
         IDLE: begin
            if (load) begin
               state_d  = SEND;
               shreg_d  = frame;
               cnt_d    = '0;
               active_d = 1'b1;
               data_d   = frame[FRAME_BITS-1 -: OUTPUT_WIDTH];
            end
         end
         SEND: begin
            // FLUSH outranks the word handshake and any preload in the same cycle
            if (FLUSH) begin
               state_d  = IDLE;
               shreg_d  = '0;
               cnt_d    = '0;
               active_d = 1'b0;
               data_d   = '0;
            end else if (handshake) begin
               if (last_word) begin
                  done_d = 1'b1;
                  cnt_d  = '0;
                  if (load) begin
                     shreg_d = frame;
                     data_d  = frame[FRAME_BITS-1 -: OUTPUT_WIDTH];
                  end else begin
                     state_d  = IDLE;
                     shreg_d  = '0;
                     active_d = 1'b0;
                     data_d   = '0;
                  end
               end else begin
                  shreg_d = shifted;
                  cnt_d   = cnt_q + CNT_W'(1);
                  data_d  = shifted[FRAME_BITS-1 -: OUTPUT_WIDTH];
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign LD_READY   = ld_ready;
   assign WR_EN      = active_q;
   assign WR_VALID   = active_q;
   assign WR_DATA    = data_q;
   assign FRAME_DONE = done_q;

endmodule
